// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encodings follow RV32M funct3 so the decoder can pass funct3 straight through.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Constants sized for the widest legal XLEN; users slice out their own width.
   localparam int MAX_XLEN = 64;
   localparam logic [MAX_XLEN-1:0] MIN_NEG  = {1'b1, {(MAX_XLEN-1){1'b0}}};
   localparam logic [MAX_XLEN-1:0] ALL_ONES = {MAX_XLEN{1'b1}};

   function automatic logic is_div(input muldiv_op_t op);
      return op[2];
   endfunction

   function automatic logic signed_a(input muldiv_op_t op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic signed_b(input muldiv_op_t op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/muldiv_assert.sv
// Handshake and result-stability properties for muldiv_unit; bound from outside
// the design so the datapath stays free of checking logic.
module muldiv_assert #(
   parameter int XLEN = 32
) (
   input logic            clk,
   input logic            reset,
   input logic            in_ready,
   input logic            out_valid,
   input logic            out_ready,
   input logic [XLEN-1:0] result,
   input logic            zero
);

   a_ready_valid_excl: assert property (@(posedge clk) disable iff (reset)
      !(in_ready && out_valid));

   a_result_hold: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(zero)));

   a_release_to_idle: assert property (@(posedge clk) disable iff (reset)
      (out_valid && out_ready) |=> in_ready);

   a_quiet_when_invalid: assert property (@(posedge clk) disable iff (reset)
      !out_valid |-> (result == '0 && !zero));

   a_zero_flag: assert property (@(posedge clk) disable iff (reset)
      out_valid |-> (zero == (result == '0)));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide, one bit per cycle, valid/ready on both sides.
// Define MULDIV_EARLY_OUT_EN to finish trivial cases (x/0, signed overflow, mul by 0) at accept.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  muldiv_op_t      op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] X_MIN  = MIN_NEG[MAX_XLEN-1 -: XLEN];
   localparam logic [XLEN-1:0] X_ONES = ALL_ONES[XLEN-1:0];

   state_t          state, state_nx;
   muldiv_op_t      op_q;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi, lo, opnd, result_q;
   logic            neg;

   logic            sa, sb, b_zero, neg_in, early;
   logic [XLEN-1:0] mag_a, mag_b, early_res;
   logic [XLEN:0]   sum, shifted, trial;
   logic [XLEN-1:0] hi_st, lo_st, div_val, div_res, fix_res;
   logic [2*XLEN-1:0] prod_abs, prod;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = result_q;
   assign zero      = (state == DONE) && (result_q == '0);

   // Operand preparation at accept: magnitudes plus the sign to restore at the end.
   always_comb begin
      sa     = signed_a(op) && in_a[XLEN-1];
      sb     = signed_b(op) && in_b[XLEN-1];
      mag_a  = sa ? -in_a : in_a;
      mag_b  = sb ? -in_b : in_b;
      b_zero = (in_b == '0);
      if ((op == REM) || (op == REMU))
         neg_in = sa;
      else if (is_div(op))
         neg_in = (sa ^ sb) && !b_zero;
      else
         neg_in = sa ^ sb;
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic ovf;
   always_comb begin
      ovf       = ((op == DIV) || (op == REM)) && (in_a == X_MIN) && (in_b == X_ONES);
      early     = 1'b0;
      early_res = '0;
      if (is_div(op)) begin
         early = b_zero || ovf;
         if (b_zero)
            early_res = ((op == DIV) || (op == DIVU)) ? X_ONES : in_a;
         else if (ovf && (op == DIV))
            early_res = in_a;
      end else begin
         early = (in_a == '0) || (in_b == '0);
      end
   end
`else
   assign early     = 1'b0;
   assign early_res = '0;
`endif

   // One iteration: hi holds the partial product / partial remainder, lo the
   // shifting multiplier / dividend-then-quotient, opnd the multiplicand / divisor.
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {hi, lo[XLEN-1]};
      trial   = shifted - {1'b0, opnd};
      hi_st   = hi;
      lo_st   = lo;
      if (is_div(op_q)) begin
         if (trial[XLEN]) begin
            hi_st = shifted[XLEN-1:0];
            lo_st = {lo[XLEN-2:0], 1'b0};
         end else begin
            hi_st = trial[XLEN-1:0];
            lo_st = {lo[XLEN-2:0], 1'b1};
         end
      end else begin
         hi_st = sum[XLEN:1];
         lo_st = {sum[0], lo[XLEN-1:1]};
      end
   end

   always_comb begin
      prod_abs = {hi_st, lo_st};
      prod     = neg ? -prod_abs : prod_abs;
      div_val  = ((op_q == DIV) || (op_q == DIVU)) ? lo_st : hi_st;
      div_res  = neg ? -div_val : div_val;
      if (is_div(op_q))
         fix_res = div_res;
      else if (op_q == MUL)
         fix_res = prod[XLEN-1:0];
      else
         fix_res = prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = early ? DONE : BUSY;
         BUSY:    if (cnt == CW'(XLEN-1)) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // NOTE: only the counter and the visible result are reset; hi/lo/opnd/op_q/neg
   // are always loaded at accept before use, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q <= op;
               cnt  <= '0;
               hi   <= '0;
               lo   <= is_div(op) ? mag_a : mag_b;
               opnd <= is_div(op) ? mag_b : mag_a;
               neg  <= neg_in;
               if (early) result_q <= early_res;
            end
            BUSY: begin
               hi  <= hi_st;
               lo  <= lo_st;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN-1)) result_q <= fix_res;
            end
            DONE: if (out_ready) result_q <= '0;
            default: result_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed corner cases, backpressure,
// reset mid-operation, back-to-back requests and randomized ops against an arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        reset;
   muldiv_op_t  op;
   logic [31:0] in_a, in_b, result;
   logic        in_valid, in_ready, zero, out_valid, out_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .zero      (zero),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   bind muldiv_unit muldiv_assert #(.XLEN(XLEN)) u_chk (
      .clk       (clk),
      .reset     (reset),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   // Reference model: RISC-V M semantics with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      r  = '0;
      case (o)
         MUL:    begin p = 64'(a) * 64'(b);         r = p[31:0];  end
         MULH:   begin p = 64'(sa * sb);            r = p[63:32]; end
         MULHSU: begin p = 64'(sa * ub);            r = p[63:32]; end
         MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         DIV:    if (b == 0) r = 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                 else r = 32'(sa / sb);
         REM:    if (b == 0) r = a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                 else r = 32'(sa % sb);
         DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         REMU:   r = (b == 0) ? a : a % b;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic int exp_latency(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (o == DIV || o == DIVU || o == REM || o == REMU) begin
         if (b == 0) return 1;
         if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      end else if (a == 0 || b == 0) begin
         return 1;
      end
`endif
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Presents one request; called with in_ready high, returns #1 after the accept edge.
   task automatic start_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
      op       = o;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts edges from the accept edge (inclusive) until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input muldiv_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat;
      int exp_lat;
      exp_lat = exp_latency(o, a, b);
      start_op(o, a, b);
      wait_valid(lat);
      checks++;
      if (lat !== exp_lat || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s latency: got %0d (out_valid=%b) expected %0d", name, lat, out_valid, exp_lat);
      end
      checks++;
      if (result !== exp) begin
         failures++;
         $display("FAIL %s result: op=%s a=%h b=%h got %h expected %h", name, o.name(), a, b, result, exp);
      end
      checks++;
      if (zero !== (exp == 32'h0)) begin
         failures++;
         $display("FAIL %s zero: got %b expected %b", name, zero, exp == 32'h0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
         failures++;
         $display("FAIL %s release: in_ready=%b out_valid=%b result=%h expected 1 0 0", name, in_ready, out_valid, result);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b1;
      op        = MUL;
      in_a      = 32'd3;
      in_b      = 32'd5;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h zero=%b expected 1 0 0 0", in_ready, out_valid, result, zero);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_priority: in_ready=%b expected 1 (request under reset must be dropped)", in_ready);
      end
   endtask

   task automatic test_directed();
      run_op("mul_7_neg3",     MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_op("mulh_min_min",   MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
      run_op("mulhu_max_max",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("mulhsu_neg1_2",  MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
      run_op("mul_by_zero",    MUL,    32'h1234_5678,  32'h0,         32'h0);
      run_op("div_overflow",   DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_overflow",   REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
      run_op("div_neg7_2",     DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
      run_op("rem_neg7_2",     REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
      run_op("divu_by_zero",   DIVU,   32'd100,        32'h0,         32'hFFFF_FFFF);
      run_op("remu_by_zero",   REMU,   32'd100,        32'h0,         32'd100);
      run_op("div_neg_by_0",   DIV,    32'hFFFF_FFF9,  32'h0,         32'hFFFF_FFFF);
      run_op("rem_neg_by_0",   REM,    32'hFFFF_FFF9,  32'h0,         32'hFFFF_FFF9);
      run_op("rem_7_neg2",     REM,    32'd7,          32'hFFFF_FFFE, 32'd1);
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         op       = DIV;
         in_a     = $urandom;
         in_b     = 32'd3;
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b result=%h expected 1 0 fffffffe", i, out_valid, in_ready, result);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL backpressure_release: in_ready=%b expected 1", in_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_no_queue: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_busy();
      bit seen_valid;
      start_op(DIVU, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         failures++;
         $display("FAIL reset_busy: out_valid=%b in_ready=%b result=%h expected 0 1 0", out_valid, in_ready, result);
      end
      seen_valid = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy_discard: out_valid seen=%b expected 0", seen_valid);
      end
      run_op("after_reset_divu", DIVU, 32'd1000, 32'd7, 32'd142);
   endtask

   task automatic test_back_to_back();
      int lat;
      for (int i = 0; i < 3; i++) begin
         start_op(MUL, 32'd10 + 32'(i), 32'd3);
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept[%0d]: in_ready=%b expected 0 right after accept", i, in_ready);
         end
         wait_valid(lat);
         checks++;
         if (result !== (32'd10 + 32'(i)) * 32'd3) begin
            failures++;
            $display("FAIL b2b_result[%0d]: got %h expected %h", i, result, (32'd10 + 32'(i)) * 32'd3);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_random();
      muldiv_op_t  o;
      logic [31:0] a, b;
      for (int i = 0; i < 150; i++) begin
         o = muldiv_op_t'($urandom_range(0, 7));
         a = pick_operand();
         b = pick_operand();
         run_op("random", o, a, b, ref_result(o, a, b));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, sets the operand and result width; legal values are 8..64, even.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 op  input  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-005 in_a  input  XLEN  operand A (multiplicand/dividend).
REQ-006 in_b  input  XLEN  operand B (multiplier/divisor).
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  unit can accept a request.
REQ-009 result  output  XLEN  operation result.
REQ-010 zero  output  1  result equals 0; qualified by out_valid.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-015 A request is accepted at the edge where in_valid and in_ready are both high; op and operands are latched, iteration counter cleared, IDLE->BUSY.
REQ-016 BUSY SHALL perform one radix-2 shift-add (mul) or restoring shift-subtract (div) iteration per cycle for exactly XLEN cycles, then BUSY->DONE.
REQ-017 Latency: out_valid SHALL rise XLEN+1 cycles after the accept cycle, i.e. 33 for XLEN=32.
REQ-018 Signed operands SHALL be converted to magnitudes before iteration and the sign fixed after; MULHSU treats A as signed and B as unsigned.
REQ-019 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-020 Divide by zero: DIV/DIVU quotient SHALL be all ones; REM/REMU SHALL return in_a.
REQ-021 Signed overflow (in_a = -2^(XLEN-1), in_b = -1): DIV SHALL return in_a, REM SHALL return 0.
REQ-022 REM SHALL take the sign of the dividend; DIV SHALL truncate toward zero.
REQ-023 In DONE, result and zero SHALL hold stable until out_ready; on the edge with out_valid and out_ready high, DONE->IDLE.
REQ-024 in_valid during BUSY/DONE SHALL be ignored, with no queuing; a new accept SHALL be possible in the cycle after the result handshake.
REQ-025 In IDLE and BUSY, result and zero SHALL be 0.

Reset
REQ-026 On reset, state SHALL go to IDLE and result, zero, out_valid and the counter SHALL clear to 0; in_ready SHALL be 1 in the following cycle.
REQ-027 Reset during BUSY or DONE SHALL discard the operation with no result produced.
REQ-028 Reset SHALL take priority over a simultaneous accept or handshake.

Configuration
REQ-029 Macro MULDIV_EARLY_OUT_EN, when defined, SHALL enable early-out: divide by zero, signed overflow, and any multiply with an operand of 0 go IDLE->DONE at the accept edge, giving latency 1.
REQ-030 Without MULDIV_EARLY_OUT_EN, every operation SHALL take XLEN+1 cycles; results SHALL be identical in both builds.

Structure
REQ-031 Package muldiv_pkg SHALL hold muldiv_op_t (encodings MUL=0 through REMU=7, matching RV32M funct3), the state enum, and the helper constants MIN_NEG and ALL_ONES.
REQ-032 The datapath and FSM SHALL reside in one module.
REQ-033 Sub-module muldiv_assert, bound in the bench, SHALL check the handshake and result stability.

Verification (XLEN=32)
REQ-034 MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-035 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 with zero=1; DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-037 DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100; latency 1 with MULDIV_EARLY_OUT_EN, 33 without.
REQ-038 Backpressure: out_ready low for 5 cycles in DONE -> result stable, in_ready 0, in_valid pulses ignored; then handshake -> in_ready 1 next cycle.
REQ-039 Reset asserted at BUSY iteration 10 -> next cycle out_valid 0, in_ready 1, result 0; a following request completes correctly.
